// File: rtl/fifo_word_reader.sv
// Read-side consumer for the FIFO_final byte FIFO: packs WORD_BYTES bytes (first byte in LSBs)
// into a word offered via valid/ready. Define WORD_XOR_CHECK_EN to add the word_xor output.
module fifo_word_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_BYTES = 4,
    parameter int CNT_W      = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_WIDTH-1:0]            fifo_data,
    input  logic                             fifo_valid,
    input  logic                             fifo_empty,
    input  logic                             fifo_underflow,
    output logic                             rd_en,
    input  logic                             flush,
    output logic [DATA_WIDTH*WORD_BYTES-1:0] word_out,
    output logic [WORD_BYTES-1:0]            word_mask,
    output logic                             word_valid,
    input  logic                             word_ready,
    output logic [CNT_W-1:0]                 byte_cnt,
    output logic                             err_underflow
`ifdef WORD_XOR_CHECK_EN
    ,
    output logic [DATA_WIDTH-1:0]            word_xor
`endif
);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_BYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] req_cnt;
    logic             flush_pend;
    logic             outstanding;
    logic             capture;
    logic             stray;
    logic             word_done;
    logic             flush_fire;
    logic             handshake;

    always_comb begin
        outstanding = (req_cnt != byte_cnt);
        capture     = (state == FILL) && fifo_valid && outstanding;
        stray       = fifo_valid && !capture;
        word_done   = capture && (byte_cnt == LAST_CNT);
        flush_fire  = (state == FILL) && flush_pend && !outstanding;
        word_valid  = (state == HOLD);
        handshake   = (state == HOLD) && word_ready;
        rd_en       = (state == FILL) && !fifo_empty && !flush_pend && (req_cnt < FULL_CNT);

        state_next = state;
        case (state)
            FILL:    if (word_done || (flush_fire && (byte_cnt != '0))) state_next = HOLD;
            HOLD:    if (word_ready) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) state <= FILL;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            word_out      <= '0;
            word_mask     <= '0;
            byte_cnt      <= '0;
            req_cnt       <= '0;
            flush_pend    <= 1'b0;
            err_underflow <= 1'b0;
`ifdef WORD_XOR_CHECK_EN
            word_xor      <= '0;
`endif
        end else begin
            if (fifo_underflow || stray) err_underflow <= 1'b1;

            if (handshake) begin
                word_out   <= '0;
                word_mask  <= '0;
                byte_cnt   <= '0;
                req_cnt    <= '0;
                flush_pend <= 1'b0;
`ifdef WORD_XOR_CHECK_EN
                word_xor   <= '0;
`endif
            end else begin
                if (rd_en) req_cnt <= req_cnt + CNT_W'(1);

                if (capture) begin
                    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                        if (byte_cnt == CNT_W'(i)) begin
                            word_out[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
                            word_mask[i]                         <= 1'b1;
                        end
                    end
                    byte_cnt <= byte_cnt + CNT_W'(1);
`ifdef WORD_XOR_CHECK_EN
                    word_xor <= word_xor ^ fifo_data;
`endif
                end

                // A completing capture wins over any flush, pending or arriving now.
                if (word_done || flush_fire)
                    flush_pend <= 1'b0;
                else if ((state == FILL) && flush)
                    flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_reader.sv
// Randomized and directed bench for fifo_word_reader: a behavioural FIFO drives the DUT and
// every accepted word is scored against the pushed byte stream.
module tb_fifo_word_reader;

    localparam int DW = 8;
    localparam int WB = 4;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   fifo_data;
    logic            fifo_valid;
    logic            fifo_empty;
    logic            fifo_underflow;
    logic            rd_en;
    logic            flush;
    logic [DW*WB-1:0] word_out;
    logic [WB-1:0]   word_mask;
    logic            word_valid;
    logic            word_ready;
    logic [CW-1:0]   byte_cnt;
    logic            err_underflow;
`ifdef WORD_XOR_CHECK_EN
    logic [DW-1:0]   word_xor;
`endif

    fifo_word_reader #(
        .DATA_WIDTH(DW),
        .WORD_BYTES(WB),
        .CNT_W     (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_data     (fifo_data),
        .fifo_valid    (fifo_valid),
        .fifo_empty    (fifo_empty),
        .fifo_underflow(fifo_underflow),
        .rd_en         (rd_en),
        .flush         (flush),
        .word_out      (word_out),
        .word_mask     (word_mask),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .byte_cnt      (byte_cnt),
        .err_underflow (err_underflow)
`ifdef WORD_XOR_CHECK_EN
        ,
        .word_xor      (word_xor)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [DW-1:0]    wr_q[$];
    logic [DW-1:0]    fq[$];
    logic [DW-1:0]    exp_stream[$];
    logic [DW*WB-1:0] got_w[$];
    logic [WB-1:0]    got_m[$];
    logic [DW-1:0]    got_x[$];
    int               rd_runs[$];
    int               lat_q[$];
    int               rd_run = 0;
    int               last_rd = 0;
    logic             wv_d = 1'b0;
    logic             flush_seen = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural FIFO: pop on rd_en, data one cycle later, empty updated on the popping edge.
    always @(posedge clk) begin
        logic [DW-1:0] b;
        cyc++;
        if (rd_en && fq.size() > 0) begin
            b = fq.pop_front();
            fifo_valid <= 1'b1;
            fifo_data  <= b;
        end else begin
            fifo_valid <= 1'b0;
        end
        while (wr_q.size() > 0) fq.push_back(wr_q.pop_front());
        fifo_empty <= (fq.size() == 0);
    end

    task automatic score_word();
        int k;
        logic [DW-1:0] b, e, x;
        k = 0;
        x = '0;
        for (int i = 0; i < WB; i++) k += int'(word_mask[i]);
        check("mask_shape", 64'(word_mask), 64'((1 << k) - 1));
        check("mask_nonzero", 64'(k != 0), 64'd1);
        if (!flush_seen) check("full_word", 64'(k), 64'(WB));
        for (int i = 0; i < WB; i++) begin
            b = word_out[i*DW +: DW];
            if (i < k) begin
                check("stream_avail", 64'(exp_stream.size() != 0), 64'd1);
                if (exp_stream.size() != 0) e = exp_stream.pop_front();
                else e = '0;
                check("byte", 64'(b), 64'(e));
                x ^= e;
            end else begin
                check("pad", 64'(b), 64'd0);
            end
        end
`ifdef WORD_XOR_CHECK_EN
        check("xor", 64'(word_xor), 64'(x));
        got_x.push_back(word_xor);
`endif
        got_w.push_back(word_out);
        got_m.push_back(word_mask);
        flush_seen = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rd_en) begin
            check("rd_vs_empty", 64'(fifo_empty), 64'd0);
            last_rd = cyc;
            rd_run++;
        end else if (rd_run != 0) begin
            rd_runs.push_back(rd_run);
            rd_run = 0;
        end
        if (word_valid && !wv_d) lat_q.push_back(cyc - last_rd);
        wv_d = word_valid;
        if (flush && !word_valid) flush_seen = 1'b1;
        if (word_valid && word_ready && !rst_n) score_word();
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [DW-1:0] b);
        wr_q.push_back(b);
        exp_stream.push_back(b);
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        tick(2);
        rst_n = 1'b0;
        exp_stream.delete();
        got_w.delete();
        got_m.delete();
        got_x.delete();
        rd_runs.delete();
        lat_q.delete();
        flush_seen = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int b = 0;
        while (got_w.size() < n && b < 300) begin
            tick(1);
            b++;
        end
        check("wait_words", 64'(got_w.size() >= n), 64'd1);
    endtask

    task automatic wait_valid();
        int b = 0;
        while (!word_valid && b < 300) begin
            tick(1);
            b++;
        end
        check("wait_valid", 64'(word_valid), 64'd1);
    endtask

    task automatic wait_bytes(input int n);
        int b = 0;
        while (byte_cnt != CW'(n) && b < 300) begin
            tick(1);
            b++;
        end
        check("wait_bytes", 64'(byte_cnt), 64'(n));
    endtask

    initial begin
        int n0;
        rst_n          = 1'b1;
        fifo_valid     = 1'b0;
        fifo_empty     = 1'b1;
        fifo_data      = '0;
        fifo_underflow = 1'b0;
        flush          = 1'b0;
        word_ready     = 1'b0;

        // Reset state
        do_reset();
        check("rst_word", 64'(word_out), 64'd0);
        check("rst_mask", 64'(word_mask), 64'd0);
        check("rst_valid", 64'(word_valid), 64'd0);
        check("rst_cnt", 64'(byte_cnt), 64'd0);
        check("rst_rd", 64'(rd_en), 64'd0);
        check("rst_err", 64'(err_underflow), 64'd0);

        // Two back-to-back full words, sink always ready
        word_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_words(2);
        tick(3);
        check("t1_w0", 64'(got_w[0]), 64'h04030201);
        check("t1_w1", 64'(got_w[1]), 64'h08070605);
        check("t1_m0", 64'(got_m[0]), 64'hf);
        check("t1_m1", 64'(got_m[1]), 64'hf);
        check("t1_runs", 64'(rd_runs.size() >= 2), 64'd1);
        if (rd_runs.size() >= 2) begin
            check("t1_run0", 64'(rd_runs[0]), 64'd4);
            check("t1_run1", 64'(rd_runs[1]), 64'd4);
        end
        check("t1_lat", 64'(lat_q.size() >= 1), 64'd1);
        if (lat_q.size() >= 1) check("t1_lat0", 64'(lat_q[0]), 64'd2);

        // Sink stalls while more data waits in the FIFO
        do_reset();
        word_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(8'(i));
        wait_valid();
        for (int i = 5; i <= 8; i++) push(8'(i));
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("t2_hold_rd", 64'(rd_en), 64'd0);
            check("t2_hold_word", 64'(word_out), 64'h04030201);
            check("t2_hold_valid", 64'(word_valid), 64'd1);
        end
        word_ready = 1'b1;
        tick(1);
        check("t2_resume_rd", 64'(rd_en), 64'd1);
        wait_words(2);
        check("t2_w0", 64'(got_w[0]), 64'h04030201);
        check("t2_w1", 64'(got_w[1]), 64'h08070605);

        // FIFO runs dry mid-word
        do_reset();
        word_ready = 1'b1;
        push(8'd1);
        push(8'd2);
        tick(10);
        check("t3_idle_rd", 64'(rd_en), 64'd0);
        check("t3_idle_cnt", 64'(byte_cnt), 64'd2);
        push(8'd3);
        push(8'd4);
        wait_words(1);
        check("t3_w0", 64'(got_w[0]), 64'h04030201);
        check("t3_err", 64'(err_underflow), 64'd0);

        // Flush a partial word
        do_reset();
        word_ready = 1'b1;
        push(8'd1);
        push(8'd2);
        push(8'd3);
        wait_bytes(3);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        wait_words(1);
        check("t4_w0", 64'(got_w[0]), 64'h00030201);
        check("t4_m0", 64'(got_m[0]), 64'h7);
`ifdef WORD_XOR_CHECK_EN
        check("t4_xor", 64'(got_x[0]), 64'h00);
`endif

        // Flush with nothing captured, then flush during HOLD
        n0 = got_w.size();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("t5_no_valid", 64'(word_valid), 64'd0);
        end
        check("t5_no_word", 64'(got_w.size()), 64'(n0));
        word_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(8'(i));
        wait_valid();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(2);
        word_ready = 1'b1;
        wait_words(n0 + 1);
        tick(8);
        check("t5_one_word", 64'(got_w.size()), 64'(n0 + 1));
        check("t5_word", 64'(got_w[n0]), 64'h04030201);
        check("t5_mask", 64'(got_m[n0]), 64'hf);

        // Reset mid-word drops the partial word
        do_reset();
        word_ready = 1'b1;
        push(8'd1);
        push(8'd2);
        wait_bytes(2);
        rst_n = 1'b1;
        tick(1);
        rst_n = 1'b0;
        exp_stream.delete();
        check("t6_word", 64'(word_out), 64'd0);
        check("t6_mask", 64'(word_mask), 64'd0);
        check("t6_cnt", 64'(byte_cnt), 64'd0);
        check("t6_valid", 64'(word_valid), 64'd0);
        for (int i = 5; i <= 8; i++) push(8'(i));
        wait_words(1);
        check("t6_w0", 64'(got_w[0]), 64'h08070605);
        fifo_underflow = 1'b1;
        tick(1);
        fifo_underflow = 1'b0;
        check("t6_err_set", 64'(err_underflow), 64'd1);
        tick(5);
        check("t6_err_sticky", 64'(err_underflow), 64'd1);
        do_reset();
        check("t6_err_clr", 64'(err_underflow), 64'd0);

        // Randomized traffic, stalls and flushes
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                int n = int'($urandom_range(1, 3));
                for (int j = 0; j < n; j++) push(8'($urandom));
            end
            word_ready = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 19) == 0);
            tick(1);
        end
        flush      = 1'b0;
        word_ready = 1'b1;
        for (int b = 0; b < 500 && exp_stream.size() > 0; b++) begin
            flush = !word_valid && (b % 4 == 0);
            tick(1);
            flush = 1'b0;
        end
        tick(4);
        check("rnd_drain", 64'(exp_stream.size()), 64'd0);
        check("rnd_err", 64'(err_underflow), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_word_reader.md
Name: fifo_word_reader

Overview:
- Read-side consumer for the team's FIFO_final byte FIFO. It drives rd_en and watches empty/valid/underflow. It captures data_out bytes and packs WORD_BYTES bytes into one word, first byte in the LSBs.
- It presents each word to a downstream sink through a valid/ready handshake.
- A flush input emits a partial word together with a byte mask.
- It sits between the FIFO and any word-wide consumer, for example a bus master or a checker.

Parameters:
- DATA_WIDTH, 8: FIFO byte width; must match FIFO_final data width.
- WORD_BYTES, 4: bytes per output word; legal range 2..8.
- CNT_W, 3: width of the byte counters; must satisfy 2^CNT_W > WORD_BYTES.

Ports:
- clk  in  1  rising-edge clock, shared with the FIFO.
- rst_n  in  1  reset. Synchronous, active-high: rst_n=1 sampled on a clk edge resets the block. The name is kept for codebase consistency.
- fifo_data  in  DATA_WIDTH  FIFO data_out.
- fifo_valid  in  1  FIFO valid; fifo_data holds good data this cycle.
- fifo_empty  in  1  FIFO empty.
- fifo_underflow  in  1  FIFO underflow flag.
- rd_en  out  1  FIFO read request.
- flush  in  1  one-cycle pulse: emit the partial word.
- word_out  out  DATA_WIDTH*WORD_BYTES  packed word.
- word_mask  out  WORD_BYTES  bit i=1 means byte i of word_out is valid.
- word_valid  out  1  word_out/word_mask are valid.
- word_ready  in  1  sink accepts the word when word_valid and word_ready are both 1.
- byte_cnt  out  CNT_W  bytes captured into the current word.
- err_underflow  out  1  sticky: FIFO underflow observed.

Behaviour:
- FIFO contract:
  - rd_en sampled high while !fifo_empty pops one byte.
  - fifo_valid/fifo_data appear exactly 1 cycle later.
  - fifo_empty is updated on the same edge that pops the last entry.
- Reset (rst_n=1 at edge) clears everything: state=FILL, rd_en=0, word_out=0, word_mask=0, word_valid=0, byte_cnt=0, the internal requested counter req_cnt=0, flush_pend=0, err_underflow=0. Reset wins over every other event, including mid-word and mid-handshake; the partial word is discarded.
- States:
  - FILL: gather bytes.
  - HOLD: word_valid=1; wait for handshake.
- rd_en is combinational: rd_en = (state==FILL) && !fifo_empty && !flush_pend && (req_cnt < WORD_BYTES). It is never asserted while fifo_empty=1. Back-to-back reads are allowed, giving one byte per cycle sustained.
- req_cnt increments on every edge where rd_en=1. Outstanding reads are always req_cnt-byte_cnt ≤ 1.
- Byte capture, on fifo_valid in FILL:
  - word_out[byte_cnt*DATA_WIDTH +: DATA_WIDTH] <= fifo_data.
  - word_mask[byte_cnt] <= 1.
  - byte_cnt <= byte_cnt+1.
- FILL -> HOLD when a capture makes byte_cnt reach WORD_BYTES. word_valid is asserted the cycle after the last fifo_valid, so latency from the last rd_en to word_valid is 2 cycles.
- flush:
  - Latched into flush_pend when sampled in FILL; ignored in HOLD.
  - With flush_pend=1 and no read outstanding (req_cnt==byte_cnt):
    - byte_cnt>0: go to HOLD with the current word_mask.
    - byte_cnt==0: clear flush_pend, no word.
  - A flush arriving in the same cycle as a capture that completes the word: the full word is emitted and the flush is dropped.
- HOLD:
  - rd_en=0. word_out, word_mask and word_valid are stable until the handshake.
  - On word_valid && word_ready: return to FILL and clear word_out, word_mask, byte_cnt, req_cnt and flush_pend on the same edge. The next rd_en can assert in the following cycle.
  - word_ready high with word_valid low has no effect.
- Unused bytes of a partial word read 0.
- A fifo_valid arriving with no read outstanding is ignored and sets err_underflow.
- err_underflow is also set by fifo_underflow=1 on any edge. Only reset clears it.

Optional Feature:
- Macro: WORD_XOR_CHECK_EN.
- Defined:
  - Adds output word_xor [DATA_WIDTH-1:0]: the XOR of all captured bytes, updated on each capture.
  - It is valid with word_valid, clears on handshake and on reset, and excludes unmasked bytes.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Write bytes 1..8 into FIFO, word_ready=1 -> two words 0x04030201 then 0x08070605, word_mask=4'b1111. rd_en runs 4 consecutive cycles per word. word_valid occurs 2 cycles after the 4th rd_en.
- Write 1..4, hold word_ready=0 for 5 cycles while the FIFO holds 5..8 -> word_out stays 0x04030201, rd_en=0 throughout HOLD. Drain resumes the cycle after the handshake.
- Write 1,2, FIFO goes empty, write 3,4 ten cycles later -> rd_en=0 while empty. Single word 0x04030201, no err_underflow.
- Write 1,2,3 then pulse flush -> word 0x00030201, mask 4'b0111. With WORD_XOR_CHECK_EN defined, word_xor=0x00.
- Pulse flush with byte_cnt=0 -> no word_valid. Pulse flush during HOLD -> ignored, no extra word.
- rst_n=1 for one edge after 2 bytes captured -> all outputs 0 next cycle, partial data lost. Next bytes 5..8 give 0x08070605. Force fifo_underflow=1 for one cycle -> err_underflow=1 until reset.
